bp_table_scheduler: RTL and testbench

Sequences all accesses to a single-ported branch-predictor counter table shared by decode-stage lookups and execute-stage feedback updates. On reset it sweeps the table to weakly-not-taken. It then serves lookups with priority and drains a small feedback queue through two-cycle read-modify-write updates. It sits inside branch_controller in place of a direct predictor instance.

---
 rtl/mips_core_pkg.sv | 29 ++
 rtl/bp_counter_ram.sv | 21 ++
 rtl/bp_table_scheduler.sv | 170 +++++++++++++++++
 tb/tb_bp_table_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types plus the predictor-table scheduler's state and counter constants.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPD_RD = 2'd2,
        UPD_WR = 2'd3
    } BpSchedState;

    localparam logic [1:0] BP_CTR_MIN = 2'b00;
    localparam logic [1:0] BP_CTR_WNT = 2'b01;
    localparam logic [1:0] BP_CTR_MAX = 2'b11;

    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input BranchOutcome outcome);
        if (outcome == TAKEN)
            return (ctr == BP_CTR_MAX) ? ctr : ctr + 2'd1;
        else
            return (ctr == BP_CTR_MIN) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_counter_ram.sv
// Single-port array of 2-bit predictor counters: async read, sync write, no reset.
module bp_counter_ram #(
    parameter int INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] addr,
    input  logic [1:0]             wdata,
    output logic [1:0]             rdata
);

    logic [1:0] mem [1 << INDEX_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bp_table_scheduler.sv
// Arbitrates the predictor table port between lookups, a feedback queue and the reset sweep.
// Optional BP_SCHED_STATS_EN adds drop / forced-stall statistics counters.
//   state  | meaning
//   INIT   | sweeping every entry to weakly-not-taken
//   IDLE   | waiting for queued feedback
//   UPD_RD | reading head entry's counter into staging
//   UPD_WR | writing saturated counter back, popping head
module bp_table_scheduler
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH  = 10,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output logic                  o_req_ready,
    output BranchOutcome          o_req_prediction,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  BranchOutcome          i_fb_outcome,
    output logic                  o_fb_full,
`ifdef BP_SCHED_STATS_EN
    output logic [15:0]           o_drop_count,
    output logic [15:0]           o_starve_count,
`endif
    output logic                  o_init_busy
);

    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [QW:0]            PTR_ONE  = (QW + 1)'(1);

    BpSchedState state, state_nxt;
    logic [INDEX_WIDTH-1:0] init_ptr;
    logic [SW-1:0]          starve_cnt;
    logic [1:0]             staged;

    logic [INDEX_WIDTH-1:0] q_idx [QUEUE_DEPTH];
    BranchOutcome           q_out [QUEUE_DEPTH];
    logic [QW:0]            head, tail;

    logic [INDEX_WIDTH-1:0] req_idx, fb_idx, head_idx;
    BranchOutcome           head_out;
    logic                   q_empty, q_full, push, pop, drop;
    logic                   upd_phase, port_free, force_upd;

    logic                   ram_we;
    logic [INDEX_WIDTH-1:0] ram_addr;
    logic [1:0]             ram_wdata, ram_rdata;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_req_pc[1:0],
                              i_fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_fb_pc[1:0]};

    assign req_idx  = i_req_pc[INDEX_WIDTH+1:2];
    assign fb_idx   = i_fb_pc[INDEX_WIDTH+1:2];
    assign head_idx = q_idx[head[QW-1:0]];
    assign head_out = q_out[head[QW-1:0]];
    assign q_empty  = (head == tail);
    assign q_full   = (head[QW] != tail[QW]) && (head[QW-1:0] == tail[QW-1:0]);

    // Update steps yield to lookups until the starve counter forces one through.
    assign upd_phase = (state == UPD_RD) || (state == UPD_WR);
    assign port_free = !i_req_valid || (starve_cnt >= SW'(STARVE_LIMIT));
    assign force_upd = upd_phase && i_req_valid && (starve_cnt >= SW'(STARVE_LIMIT));

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = req_idx;
        ram_wdata = BP_CTR_WNT;
        pop       = 1'b0;
        case (state)
            INIT: begin
                ram_we   = 1'b1;
                ram_addr = init_ptr;
                if (init_ptr == LAST_IDX)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (!q_empty)
                    state_nxt = UPD_RD;
            end
            UPD_RD: begin
                if (port_free) begin
                    ram_addr  = head_idx;
                    state_nxt = UPD_WR;
                end
            end
            UPD_WR: begin
                if (port_free) begin
                    ram_we    = 1'b1;
                    ram_addr  = head_idx;
                    ram_wdata = bp_ctr_next(staged, head_out);
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // A full queue still takes a push when the head leaves in the same cycle.
    assign push = i_fb_valid && (!q_full || pop);
    assign drop = i_fb_valid && q_full && !pop;

    assign o_req_ready      = (state != INIT) && !force_upd;
    assign o_req_prediction = (o_req_ready && ram_rdata[1]) ? TAKEN : NOT_TAKEN;
    assign o_fb_full        = q_full;
    assign o_init_busy      = (state == INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_ptr   <= '0;
            starve_cnt <= '0;
            staged     <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                init_ptr <= init_ptr + INDEX_WIDTH'(1);
            if (upd_phase)
                starve_cnt <= port_free ? '0 : starve_cnt + SW'(1);
            if (state == UPD_RD && port_free)
                staged <= ram_rdata;
            if (pop)
                head <= head + PTR_ONE;
            if (push)
                tail <= tail + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail[QW-1:0]] <= fb_idx;
            q_out[tail[QW-1:0]] <= i_fb_outcome;
        end
    end

`ifdef BP_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_drop_count   <= '0;
            o_starve_count <= '0;
        end else begin
            if (drop && o_drop_count != 16'hFFFF)
                o_drop_count <= o_drop_count + 16'd1;
            if (force_upd && o_starve_count != 16'hFFFF)
                o_starve_count <= o_starve_count + 16'd1;
        end
    end
`endif

    bp_counter_ram #(
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Directed bench for bp_table_scheduler with INDEX_WIDTH=6 (pc 0x40 maps to entry 0x10).
module tb_bp_table_scheduler;
    import mips_core_pkg::*;

    localparam int IW = 6;
    localparam int TABLE_SIZE = 1 << IW;

    logic                  clk;
    logic                  rst_n;
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_pc;
    logic                  o_req_ready;
    BranchOutcome          o_req_prediction;
    logic                  i_fb_valid;
    logic [ADDR_WIDTH-1:0] i_fb_pc;
    BranchOutcome          i_fb_outcome;
    logic                  o_fb_full;
    logic                  o_init_busy;
`ifdef BP_SCHED_STATS_EN
    logic [15:0]           o_drop_count;
    logic [15:0]           o_starve_count;
`endif

    bp_table_scheduler #(
        .INDEX_WIDTH (IW),
        .QUEUE_DEPTH (4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req_valid     (i_req_valid),
        .i_req_pc        (i_req_pc),
        .o_req_ready     (o_req_ready),
        .o_req_prediction(o_req_prediction),
        .i_fb_valid      (i_fb_valid),
        .i_fb_pc         (i_fb_pc),
        .i_fb_outcome    (i_fb_outcome),
        .o_fb_full       (o_fb_full),
`ifdef BP_SCHED_STATS_EN
        .o_drop_count    (o_drop_count),
        .o_starve_count  (o_starve_count),
`endif
        .o_init_busy     (o_init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic         exp_ready;
        BranchOutcome exp_pred;
    } lookup_vec_t;

    int tests_run;
    int tests_failed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc, input BranchOutcome exp);
        i_req_valid = 1'b1;
        i_req_pc    = pc;
        #1;
        check({name, "_ready"}, 32'(o_req_ready), 32'd1);
        check({name, "_pred"}, 32'(o_req_prediction), 32'(exp));
        i_req_valid = 1'b0;
    endtask

    // Uncontended update: enqueue at edge t, written at t+3, looked up in the t+3..t+4 cycle.
    task automatic send_fb(input string name, input logic [31:0] pc, input BranchOutcome outc,
                           input BranchOutcome exp_pred);
        i_req_valid  = 1'b0;
        i_fb_valid   = 1'b1;
        i_fb_pc      = pc;
        i_fb_outcome = outc;
        tick();
        i_fb_valid = 1'b0;
        repeat (3) tick();
        lookup(name, pc, exp_pred);
    endtask

    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        while (o_init_busy && cnt < 4 * TABLE_SIZE) begin
            tick();
            cnt++;
            i_fb_valid = 1'b0;
        end
        check(name, 32'(cnt), 32'(TABLE_SIZE));
    endtask

    lookup_vec_t init_vecs[8];
    lookup_vec_t final_vecs[6];

    initial begin
        logic [31:0] mask;
        tests_run    = 0;
        tests_failed = 0;

        init_vecs[0] = '{32'h0000_0000, 1'b1, NOT_TAKEN};
        init_vecs[1] = '{32'h0000_0004, 1'b1, NOT_TAKEN};
        init_vecs[2] = '{32'h0000_0040, 1'b1, NOT_TAKEN};
        init_vecs[3] = '{32'h0000_0043, 1'b1, NOT_TAKEN};
        init_vecs[4] = '{32'h0000_00FC, 1'b1, NOT_TAKEN};
        init_vecs[5] = '{32'hFFFF_FF00, 1'b1, NOT_TAKEN};
        init_vecs[6] = '{32'h0000_1080, 1'b1, NOT_TAKEN};
        init_vecs[7] = '{32'h8000_0090, 1'b1, NOT_TAKEN};

        // After the mid-operation reset only the feedback pushed during the sweep survives.
        final_vecs[0] = '{32'h0000_0010, 1'b1, TAKEN};
        final_vecs[1] = '{32'h0000_0040, 1'b1, NOT_TAKEN};
        final_vecs[2] = '{32'h0000_0080, 1'b1, NOT_TAKEN};
        final_vecs[3] = '{32'h0000_0090, 1'b1, NOT_TAKEN};
        final_vecs[4] = '{32'h0000_00C0, 1'b1, NOT_TAKEN};
        final_vecs[5] = '{32'h0000_0014, 1'b1, NOT_TAKEN};

        rst_n        = 1'b0;
        i_req_valid  = 1'b1;
        i_req_pc     = 32'h40;
        i_fb_valid   = 1'b0;
        i_fb_pc      = '0;
        i_fb_outcome = NOT_TAKEN;
        tick();
        tick();
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_pred", 32'(o_req_prediction), 32'(NOT_TAKEN));
        check("rst_full", 32'(o_fb_full), 32'd0);
        check("rst_busy", 32'(o_init_busy), 32'd1);
`ifdef BP_SCHED_STATS_EN
        check("rst_drop_cnt", 32'(o_drop_count), 32'd0);
        check("rst_starve_cnt", 32'(o_starve_count), 32'd0);
`endif
        rst_n = 1'b1;
        i_req_valid = 1'b0;
        wait_init("init_cycles");

        for (int i = 0; i < 8; i++) begin
            i_req_valid = 1'b1;
            i_req_pc    = init_vecs[i].pc;
            #1;
            check($sformatf("init_vec%0d_ready", i), 32'(o_req_ready), 32'(init_vecs[i].exp_ready));
            check($sformatf("init_vec%0d_pred", i), 32'(o_req_prediction), 32'(init_vecs[i].exp_pred));
        end
        i_req_valid = 1'b0;
        tick();

        // Entry 0x10: 01 -> 10 -> 11 -> 11 (saturate) -> 10 -> 01.
        send_fb("t1_0x40", 32'h40, TAKEN, TAKEN);
        send_fb("t2_0x40", 32'h40, TAKEN, TAKEN);
        send_fb("t3_0x40_sat", 32'h40, TAKEN, TAKEN);
        send_fb("n1_0x40", 32'h40, NOT_TAKEN, TAKEN);
        send_fb("n2_0x40", 32'h40, NOT_TAKEN, NOT_TAKEN);
        // Entry 0x11: 01 -> 00 -> 00 (saturate) -> 01 -> 10.
        send_fb("n1_0x44", 32'h44, NOT_TAKEN, NOT_TAKEN);
        send_fb("n2_0x44_sat", 32'h44, NOT_TAKEN, NOT_TAKEN);
        send_fb("t1_0x44", 32'h44, TAKEN, NOT_TAKEN);
        send_fb("t2_0x44", 32'h44, TAKEN, TAKEN);

        // Five back-to-back feedbacks with lookups holding the port: the fifth is dropped.
        i_req_valid = 1'b1;
        i_req_pc    = 32'h40;
        for (int k = 0; k < 5; k++) begin
            i_fb_valid   = 1'b1;
            i_fb_pc      = (k < 4) ? 32'h80 : 32'h84;
            i_fb_outcome = TAKEN;
            tick();
            if (k == 2)
                check("full_after3", 32'(o_fb_full), 32'd0);
            if (k == 3)
                check("full_after4", 32'(o_fb_full), 32'd1);
        end
        i_fb_valid = 1'b0;
        check("full_after_drop", 32'(o_fb_full), 32'd1);
`ifdef BP_SCHED_STATS_EN
        check("drop_cnt", 32'(o_drop_count), 32'd1);
`endif
        i_req_valid = 1'b0;
        repeat (20) tick();
        check("full_drained", 32'(o_fb_full), 32'd0);
        lookup("queued_0x80", 32'h80, TAKEN);
        lookup("dropped_0x84", 32'h84, NOT_TAKEN);
        tick();

        // One queued update against continuous lookups: forced steps at +9 and +18.
        i_req_valid  = 1'b1;
        i_req_pc     = 32'h40;
        i_fb_valid   = 1'b1;
        i_fb_pc      = 32'h90;
        i_fb_outcome = TAKEN;
        tick();
        i_fb_valid = 1'b0;
        mask = '0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (!o_req_ready)
                mask[k] = 1'b1;
        end
        check("starve_mask", mask, (32'd1 << 9) | (32'd1 << 18));
`ifdef BP_SCHED_STATS_EN
        check("starve_cnt", 32'(o_starve_count), 32'd2);
`endif
        lookup("starved_0x90", 32'h90, TAKEN);
        tick();

        // Reset while the update for 0xC0 sits staged in UPD_WR.
        i_req_valid  = 1'b0;
        i_fb_valid   = 1'b1;
        i_fb_pc      = 32'hC0;
        i_fb_outcome = TAKEN;
        tick();
        i_fb_valid = 1'b0;
        tick();
        tick();
        rst_n       = 1'b0;
        i_req_valid = 1'b1;
        i_req_pc    = 32'hC0;
        #1;
        check("mid_rst_busy", 32'(o_init_busy), 32'd1);
        check("mid_rst_ready", 32'(o_req_ready), 32'd0);
        check("mid_rst_pred", 32'(o_req_prediction), 32'(NOT_TAKEN));
`ifdef BP_SCHED_STATS_EN
        check("mid_rst_drop_cnt", 32'(o_drop_count), 32'd0);
`endif
        tick();
        tick();
        rst_n        = 1'b1;
        i_req_valid  = 1'b0;
        i_fb_valid   = 1'b1;
        i_fb_pc      = 32'h10;
        i_fb_outcome = TAKEN;
        wait_init("reinit_cycles");
        i_fb_valid = 1'b0;
        repeat (10) tick();
        check("reinit_full", 32'(o_fb_full), 32'd0);

        for (int i = 0; i < 6; i++) begin
            i_req_valid = 1'b1;
            i_req_pc    = final_vecs[i].pc;
            #1;
            check($sformatf("final_vec%0d_ready", i), 32'(o_req_ready), 32'(final_vecs[i].exp_ready));
            check($sformatf("final_vec%0d_pred", i), 32'(o_req_prediction), 32'(final_vecs[i].exp_pred));
        end
        i_req_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
